// File: rtl/ddr_axi_calib_gate.sv
// AXI4 gate between the SoC DDR master port and the DDR4 controller slave.
// Blocks traffic until calibration has settled, bounds outstanding bursts
// per direction, drains in-flight bursts on calibration loss or flush and
// zero-extends 32b SoC addresses to the controller address width.
// Ports:
//   ddr_clk_i, ddr_rst        UI clock, async active-high reset
//   calib_complete_i          controller calibration done (level)
//   flush_i                   drain request (level, honoured while open)
//   s_{aw,w,b,ar,r}_*         AXI4 slave side from the SoC (32b addr)
//   m_{aw,w,b,ar,r}_*         AXI4 master side to the controller
//   gate_open_o               traffic is open
//   rd/wr_outstanding_o       live read / write burst counts
module ddr_axi_calib_gate #(
    parameter int unsigned SettleCycles   = 64,
    parameter int unsigned MaxOutstanding = 8,
    parameter int unsigned MAddrWidth     = 34
) (
    input  logic                                  ddr_clk_i,
    input  logic                                  ddr_rst,
    input  logic                                  calib_complete_i,
    input  logic                                  flush_i,
    // SoC AW
    input  logic                                  s_aw_valid_i,
    output logic                                  s_aw_ready_o,
    input  logic                                  s_aw_id_i,
    input  logic [31:0]                           s_aw_addr_i,
    input  logic [7:0]                            s_aw_len_i,
    input  logic [2:0]                            s_aw_size_i,
    input  logic [1:0]                            s_aw_burst_i,
    // SoC W
    input  logic                                  s_w_valid_i,
    output logic                                  s_w_ready_o,
    input  logic [255:0]                          s_w_data_i,
    input  logic [31:0]                           s_w_strb_i,
    input  logic                                  s_w_last_i,
    // SoC B
    output logic                                  s_b_valid_o,
    input  logic                                  s_b_ready_i,
    output logic                                  s_b_id_o,
    output logic [1:0]                            s_b_resp_o,
    // SoC AR
    input  logic                                  s_ar_valid_i,
    output logic                                  s_ar_ready_o,
    input  logic                                  s_ar_id_i,
    input  logic [31:0]                           s_ar_addr_i,
    input  logic [7:0]                            s_ar_len_i,
    input  logic [2:0]                            s_ar_size_i,
    input  logic [1:0]                            s_ar_burst_i,
    // SoC R
    output logic                                  s_r_valid_o,
    input  logic                                  s_r_ready_i,
    output logic                                  s_r_id_o,
    output logic [255:0]                          s_r_data_o,
    output logic [1:0]                            s_r_resp_o,
    output logic                                  s_r_last_o,
    // Controller AW
    output logic                                  m_aw_valid_o,
    input  logic                                  m_aw_ready_i,
    output logic                                  m_aw_id_o,
    output logic [MAddrWidth-1:0]                 m_aw_addr_o,
    output logic [7:0]                            m_aw_len_o,
    output logic [2:0]                            m_aw_size_o,
    output logic [1:0]                            m_aw_burst_o,
    // Controller W
    output logic                                  m_w_valid_o,
    input  logic                                  m_w_ready_i,
    output logic [255:0]                          m_w_data_o,
    output logic [31:0]                           m_w_strb_o,
    output logic                                  m_w_last_o,
    // Controller B
    input  logic                                  m_b_valid_i,
    output logic                                  m_b_ready_o,
    input  logic                                  m_b_id_i,
    input  logic [1:0]                            m_b_resp_i,
    // Controller AR
    output logic                                  m_ar_valid_o,
    input  logic                                  m_ar_ready_i,
    output logic                                  m_ar_id_o,
    output logic [MAddrWidth-1:0]                 m_ar_addr_o,
    output logic [7:0]                            m_ar_len_o,
    output logic [2:0]                            m_ar_size_o,
    output logic [1:0]                            m_ar_burst_o,
    // Controller R
    input  logic                                  m_r_valid_i,
    output logic                                  m_r_ready_o,
    input  logic                                  m_r_id_i,
    input  logic [255:0]                          m_r_data_i,
    input  logic [1:0]                            m_r_resp_i,
    input  logic                                  m_r_last_i,
    // Status
    output logic                                  gate_open_o,
    output logic [$clog2(MaxOutstanding+1)-1:0]   rd_outstanding_o,
    output logic [$clog2(MaxOutstanding+1)-1:0]   wr_outstanding_o
);

    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
    localparam int unsigned SetW = (SettleCycles > 1) ? $clog2(SettleCycles) : 1;
    localparam logic [CntW-1:0] MaxCnt  = CntW'(MaxOutstanding);
    localparam logic [SetW-1:0] SetLast = SetW'(SettleCycles - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        OPEN   = 2'd2,
        DRAIN  = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [SetW-1:0] settle_q, settle_d;
    logic [CntW-1:0] rd_cnt_q, rd_cnt_d;
    logic [CntW-1:0] wr_cnt_q, wr_cnt_d;
    // AW accepted whose W-last has not yet passed
    logic [CntW-1:0] wd_cnt_q, wd_cnt_d;

    logic allow_rd, allow_wr, w_phase, w_allow;
    logic ar_hs, aw_hs, w_last_hs, b_hs, r_last_hs;

    // State register
    always_ff @(posedge ddr_clk_i or posedge ddr_rst) begin
        if (ddr_rst) begin
            state_q  <= IDLE;
            settle_q <= '0;
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
            wd_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
            wd_cnt_q <= wd_cnt_d;
        end
    end

    // Next state; drain exit looks at next-cycle counts so the gate
    // returns to IDLE on the same edge the last burst retires.
    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        unique case (state_q)
            IDLE: begin
                if (calib_complete_i) begin
                    state_d  = SETTLE;
                    settle_d = '0;
                end
            end
            SETTLE: begin
                if (!calib_complete_i) begin
                    state_d = IDLE;
                end else if (settle_q == SetLast) begin
                    state_d = OPEN;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            OPEN: begin
                if (!calib_complete_i || flush_i) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (rd_cnt_d == '0 && wr_cnt_d == '0 && wd_cnt_d == '0) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs of the state machine
    always_comb begin
        gate_open_o = (state_q == OPEN);
        w_phase     = (state_q == OPEN) || (state_q == DRAIN);
        allow_rd    = gate_open_o && (rd_cnt_q < MaxCnt);
        allow_wr    = gate_open_o && (wr_cnt_q < MaxCnt);
    end

    // AR
    assign m_ar_valid_o = s_ar_valid_i & allow_rd;
    assign s_ar_ready_o = m_ar_ready_i & allow_rd;
    assign m_ar_id_o    = s_ar_id_i;
    assign m_ar_addr_o  = MAddrWidth'(s_ar_addr_i);
    assign m_ar_len_o   = s_ar_len_i;
    assign m_ar_size_o  = s_ar_size_i;
    assign m_ar_burst_o = s_ar_burst_i;
    assign ar_hs        = s_ar_valid_i & s_ar_ready_o;

    // AW
    assign m_aw_valid_o = s_aw_valid_i & allow_wr;
    assign s_aw_ready_o = m_aw_ready_i & allow_wr;
    assign m_aw_id_o    = s_aw_id_i;
    assign m_aw_addr_o  = MAddrWidth'(s_aw_addr_i);
    assign m_aw_len_o   = s_aw_len_i;
    assign m_aw_size_o  = s_aw_size_i;
    assign m_aw_burst_o = s_aw_burst_i;
    assign aw_hs        = s_aw_valid_i & s_aw_ready_o;

    // W may only follow an accepted (or concurrently accepted) AW
    assign w_allow     = w_phase & ((wd_cnt_q != '0) | aw_hs);
    assign m_w_valid_o = s_w_valid_i & w_allow;
    assign s_w_ready_o = m_w_ready_i & w_allow;
    assign m_w_data_o  = s_w_data_i;
    assign m_w_strb_o  = s_w_strb_i;
    assign m_w_last_o  = s_w_last_i;
    assign w_last_hs   = s_w_valid_i & s_w_ready_o & s_w_last_i;

    // B and R are never gated
    assign s_b_valid_o = m_b_valid_i;
    assign m_b_ready_o = s_b_ready_i;
    assign s_b_id_o    = m_b_id_i;
    assign s_b_resp_o  = m_b_resp_i;
    assign b_hs        = m_b_valid_i & s_b_ready_i;

    assign s_r_valid_o = m_r_valid_i;
    assign m_r_ready_o = s_r_ready_i;
    assign s_r_id_o    = m_r_id_i;
    assign s_r_data_o  = m_r_data_i;
    assign s_r_resp_o  = m_r_resp_i;
    assign s_r_last_o  = m_r_last_i;
    assign r_last_hs   = m_r_valid_i & s_r_ready_i & m_r_last_i;

    // Outstanding counters
    always_comb begin
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        wd_cnt_d = wd_cnt_q;
        if (ar_hs && !r_last_hs) begin
            rd_cnt_d = rd_cnt_q + 1'b1;
        end else if (!ar_hs && r_last_hs) begin
            rd_cnt_d = rd_cnt_q - 1'b1;
        end
        if (aw_hs && !b_hs) begin
            wr_cnt_d = wr_cnt_q + 1'b1;
        end else if (!aw_hs && b_hs) begin
            wr_cnt_d = wr_cnt_q - 1'b1;
        end
        if (aw_hs && !w_last_hs) begin
            wd_cnt_d = wd_cnt_q + 1'b1;
        end else if (!aw_hs && w_last_hs) begin
            wd_cnt_d = wd_cnt_q - 1'b1;
        end
    end

    assign rd_outstanding_o = rd_cnt_q;
    assign wr_outstanding_o = wr_cnt_q;

    // A retirement with nothing outstanding is a protocol error upstream
    a_rd_underflow: assert property (@(posedge ddr_clk_i) disable iff (ddr_rst)
        !(r_last_hs && rd_cnt_q == '0));
    a_wr_underflow: assert property (@(posedge ddr_clk_i) disable iff (ddr_rst)
        !(b_hs && wr_cnt_q == '0));
    a_rd_bound: assert property (@(posedge ddr_clk_i) disable iff (ddr_rst)
        rd_cnt_q <= MaxCnt);
    a_wr_bound: assert property (@(posedge ddr_clk_i) disable iff (ddr_rst)
        wr_cnt_q <= MaxCnt);
    a_wd_bound: assert property (@(posedge ddr_clk_i) disable iff (ddr_rst)
        wd_cnt_q <= MaxCnt);

endmodule

// File: tb/tb_ddr_axi_calib_gate.sv
// Bench for ddr_axi_calib_gate: random AXI fields, scoreboard queues per
// channel and a cycle-level model of the gate's open/drain/count rules.
module tb_ddr_axi_calib_gate;

    localparam int SETTLE = 64;
    localparam int MAXO   = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic calib, flush;
    logic s_aw_valid, s_aw_ready, s_aw_id;
    logic [31:0] s_aw_addr;
    logic [7:0] s_aw_len;
    logic [2:0] s_aw_size;
    logic [1:0] s_aw_burst;
    logic s_w_valid, s_w_ready, s_w_last;
    logic [255:0] s_w_data;
    logic [31:0] s_w_strb;
    logic s_b_valid, s_b_ready, s_b_id;
    logic [1:0] s_b_resp;
    logic s_ar_valid, s_ar_ready, s_ar_id;
    logic [31:0] s_ar_addr;
    logic [7:0] s_ar_len;
    logic [2:0] s_ar_size;
    logic [1:0] s_ar_burst;
    logic s_r_valid, s_r_ready, s_r_id, s_r_last;
    logic [255:0] s_r_data;
    logic [1:0] s_r_resp;
    logic m_aw_valid, m_aw_ready, m_aw_id;
    logic [33:0] m_aw_addr;
    logic [7:0] m_aw_len;
    logic [2:0] m_aw_size;
    logic [1:0] m_aw_burst;
    logic m_w_valid, m_w_ready, m_w_last;
    logic [255:0] m_w_data;
    logic [31:0] m_w_strb;
    logic m_b_valid, m_b_ready, m_b_id;
    logic [1:0] m_b_resp;
    logic m_ar_valid, m_ar_ready, m_ar_id;
    logic [33:0] m_ar_addr;
    logic [7:0] m_ar_len;
    logic [2:0] m_ar_size;
    logic [1:0] m_ar_burst;
    logic m_r_valid, m_r_ready, m_r_id, m_r_last;
    logic [255:0] m_r_data;
    logic [1:0] m_r_resp;
    logic gate_open;
    logic [3:0] rd_out, wr_out;

    ddr_axi_calib_gate #(
        .SettleCycles(SETTLE), .MaxOutstanding(MAXO), .MAddrWidth(34)
    ) dut (
        .ddr_clk_i(clk), .ddr_rst(rst),
        .calib_complete_i(calib), .flush_i(flush),
        .s_aw_valid_i(s_aw_valid), .s_aw_ready_o(s_aw_ready),
        .s_aw_id_i(s_aw_id), .s_aw_addr_i(s_aw_addr), .s_aw_len_i(s_aw_len),
        .s_aw_size_i(s_aw_size), .s_aw_burst_i(s_aw_burst),
        .s_w_valid_i(s_w_valid), .s_w_ready_o(s_w_ready),
        .s_w_data_i(s_w_data), .s_w_strb_i(s_w_strb), .s_w_last_i(s_w_last),
        .s_b_valid_o(s_b_valid), .s_b_ready_i(s_b_ready),
        .s_b_id_o(s_b_id), .s_b_resp_o(s_b_resp),
        .s_ar_valid_i(s_ar_valid), .s_ar_ready_o(s_ar_ready),
        .s_ar_id_i(s_ar_id), .s_ar_addr_i(s_ar_addr), .s_ar_len_i(s_ar_len),
        .s_ar_size_i(s_ar_size), .s_ar_burst_i(s_ar_burst),
        .s_r_valid_o(s_r_valid), .s_r_ready_i(s_r_ready), .s_r_id_o(s_r_id),
        .s_r_data_o(s_r_data), .s_r_resp_o(s_r_resp), .s_r_last_o(s_r_last),
        .m_aw_valid_o(m_aw_valid), .m_aw_ready_i(m_aw_ready),
        .m_aw_id_o(m_aw_id), .m_aw_addr_o(m_aw_addr), .m_aw_len_o(m_aw_len),
        .m_aw_size_o(m_aw_size), .m_aw_burst_o(m_aw_burst),
        .m_w_valid_o(m_w_valid), .m_w_ready_i(m_w_ready),
        .m_w_data_o(m_w_data), .m_w_strb_o(m_w_strb), .m_w_last_o(m_w_last),
        .m_b_valid_i(m_b_valid), .m_b_ready_o(m_b_ready),
        .m_b_id_i(m_b_id), .m_b_resp_i(m_b_resp),
        .m_ar_valid_o(m_ar_valid), .m_ar_ready_i(m_ar_ready),
        .m_ar_id_o(m_ar_id), .m_ar_addr_o(m_ar_addr), .m_ar_len_o(m_ar_len),
        .m_ar_size_o(m_ar_size), .m_ar_burst_o(m_ar_burst),
        .m_r_valid_i(m_r_valid), .m_r_ready_o(m_r_ready), .m_r_id_i(m_r_id),
        .m_r_data_i(m_r_data), .m_r_resp_i(m_r_resp), .m_r_last_i(m_r_last),
        .gate_open_o(gate_open),
        .rd_outstanding_o(rd_out), .wr_outstanding_o(wr_out)
    );

    int n_chk = 0;
    int n_fail = 0;

    function automatic void check(input string nm, input logic [511:0] act,
                                  input logic [511:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    // Scoreboard queues, filled by stimulus, drained by the monitor
    logic [47:0]  ar_q[$];
    logic [47:0]  aw_q[$];
    logic [288:0] w_q[$];
    logic [2:0]   b_q[$];
    logic [259:0] r_q[$];

    // Model: gate opens once calib is sampled high on SETTLE+1
    // consecutive edges after the gate last became idle.
    bit m_open, m_drain;
    int m_run, m_rd, m_wr, m_wd;

    always @(negedge clk) begin
        bit al_r, al_w, arh, awh, wok, wh, rl, bh;
        check("b_r_pass", {s_b_valid, m_b_ready, s_r_valid, m_r_ready},
              {m_b_valid, s_b_ready, m_r_valid, s_r_ready});
        if (s_b_valid && s_b_ready) begin
            check("b_queued", b_q.size() != 0, 1'b1);
            if (b_q.size() != 0) check("b_data", {s_b_id, s_b_resp}, b_q.pop_front());
        end
        if (s_r_valid && s_r_ready) begin
            check("r_queued", r_q.size() != 0, 1'b1);
            if (r_q.size() != 0)
                check("r_data", {s_r_id, s_r_data, s_r_resp, s_r_last}, r_q.pop_front());
        end
        if (rst) begin
            m_open = 0; m_drain = 0; m_run = 0;
            m_rd = 0; m_wr = 0; m_wd = 0;
            check("reset_outs", {gate_open, rd_out, wr_out, s_ar_ready, m_ar_valid,
                  s_aw_ready, m_aw_valid, s_w_ready, m_w_valid}, '0);
        end else begin
            al_r = m_open && m_rd < MAXO;
            al_w = m_open && m_wr < MAXO;
            arh  = s_ar_valid && m_ar_ready && al_r;
            awh  = s_aw_valid && m_aw_ready && al_w;
            wok  = (m_open || m_drain) && (m_wd > 0 || awh);
            wh   = s_w_valid && m_w_ready && wok;
            rl   = m_r_valid && s_r_ready && m_r_last;
            bh   = m_b_valid && s_b_ready;
            check("gating", {s_ar_ready, m_ar_valid, s_aw_ready, m_aw_valid,
                  s_w_ready, m_w_valid},
                  {m_ar_ready && al_r, s_ar_valid && al_r, m_aw_ready && al_w,
                   s_aw_valid && al_w, m_w_ready && wok, s_w_valid && wok});
            check("status", {gate_open, rd_out, wr_out},
                  {m_open, 4'(m_rd), 4'(m_wr)});
            if (m_ar_valid && m_ar_ready) begin
                check("ar_queued", ar_q.size() != 0, 1'b1);
                if (ar_q.size() != 0)
                    check("ar_data", {m_ar_id, m_ar_addr, m_ar_len, m_ar_size,
                          m_ar_burst}, ar_q.pop_front());
            end
            if (m_aw_valid && m_aw_ready) begin
                check("aw_queued", aw_q.size() != 0, 1'b1);
                if (aw_q.size() != 0)
                    check("aw_data", {m_aw_id, m_aw_addr, m_aw_len, m_aw_size,
                          m_aw_burst}, aw_q.pop_front());
            end
            if (m_w_valid && m_w_ready) begin
                check("w_queued", w_q.size() != 0, 1'b1);
                if (w_q.size() != 0)
                    check("w_data", {m_w_data, m_w_strb, m_w_last}, w_q.pop_front());
            end
            // advance the model to the state after the coming edge
            m_rd += int'(arh) - int'(rl);
            m_wr += int'(awh) - int'(bh);
            m_wd += int'(awh) - int'(wh && s_w_last);
            if (m_open) begin
                if (!calib || flush) begin
                    m_open = 0;
                    m_drain = 1;
                end
            end else if (m_drain) begin
                if (m_rd == 0 && m_wr == 0 && m_wd == 0) begin
                    m_drain = 0;
                    m_run = 0;
                end
            end else begin
                m_run = calib ? m_run + 1 : 0;
                if (m_run == SETTLE + 1) m_open = 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ar_send(input logic id, input logic [31:0] addr, input logic [7:0] len);
        s_ar_id = id; s_ar_addr = addr; s_ar_len = len;
        s_ar_size = 3'd5; s_ar_burst = 2'b01; s_ar_valid = 1'b1;
        ar_q.push_back({id, 2'b00, addr, len, 3'd5, 2'b01});
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (s_ar_ready) break;
        end
        check("ar_accept", s_ar_ready, 1'b1);
        tick();
        s_ar_valid = 1'b0;
    endtask

    task automatic aw_send(input logic id, input logic [31:0] addr, input logic [7:0] len);
        s_aw_id = id; s_aw_addr = addr; s_aw_len = len;
        s_aw_size = 3'd5; s_aw_burst = 2'b01; s_aw_valid = 1'b1;
        aw_q.push_back({id, 2'b00, addr, len, 3'd5, 2'b01});
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (s_aw_ready) break;
        end
        check("aw_accept", s_aw_ready, 1'b1);
        tick();
        s_aw_valid = 1'b0;
    endtask

    task automatic w_present(input logic last);
        s_w_data = {$urandom, $urandom, $urandom, $urandom,
                    $urandom, $urandom, $urandom, $urandom};
        s_w_strb = $urandom;
        s_w_last = last;
        s_w_valid = 1'b1;
    endtask

    task automatic w_beat(input logic last);
        w_present(last);
        w_q.push_back({s_w_data, s_w_strb, last});
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (s_w_ready) break;
        end
        check("w_accept", s_w_ready, 1'b1);
        tick();
        s_w_valid = 1'b0;
    endtask

    task automatic b_beat(input logic id);
        m_b_id = id; m_b_resp = 2'($urandom); m_b_valid = 1'b1;
        b_q.push_back({id, m_b_resp});
        tick();
        m_b_valid = 1'b0;
    endtask

    task automatic r_beat(input logic id, input logic last);
        m_r_id = id; m_r_resp = 2'($urandom); m_r_last = last;
        m_r_data = {$urandom, $urandom, $urandom, $urandom,
                    $urandom, $urandom, $urandom, $urandom};
        m_r_valid = 1'b1;
        r_q.push_back({id, m_r_data, m_r_resp, last});
        tick();
        m_r_valid = 1'b0;
    endtask

    task automatic wait_open(output int n);
        n = 0;
        for (int k = 1; k <= 300; k++) begin
            @(posedge clk);
            #1;
            n = k;
            if (gate_open) break;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        calib = 0; flush = 0;
        s_aw_valid = 0; s_aw_id = 0; s_aw_addr = 0; s_aw_len = 0;
        s_aw_size = 0; s_aw_burst = 0;
        s_w_valid = 0; s_w_data = '0; s_w_strb = 0; s_w_last = 0;
        s_ar_valid = 0; s_ar_id = 0; s_ar_addr = 0; s_ar_len = 0;
        s_ar_size = 0; s_ar_burst = 0;
        m_b_valid = 0; m_b_id = 0; m_b_resp = 0;
        m_r_valid = 0; m_r_id = 0; m_r_data = '0; m_r_resp = 0; m_r_last = 0;
        s_b_ready = 1; s_r_ready = 1;
        m_ar_ready = 1; m_aw_ready = 1; m_w_ready = 1;
        repeat (3) tick();
        rst = 0;

        // 1: held off while uncalibrated, opens SETTLE edges after calib
        s_ar_id = 1; s_ar_addr = $urandom; s_ar_len = 8'd3;
        s_ar_size = 3'd5; s_ar_burst = 2'b01; s_ar_valid = 1;
        ar_q.push_back({1'b1, 2'b00, s_ar_addr, 8'd3, 3'd5, 2'b01});
        repeat (100) tick();
        check("t1_blocked", {s_ar_ready, m_ar_valid}, 2'b00);
        calib = 1;
        tick();
        n = 0;
        for (int k = 1; k <= 300; k++) begin
            @(posedge clk);
            #1;
            n = k;
            if (m_ar_valid) break;
        end
        check("t1_settle_edges", n, SETTLE);
        tick();
        s_ar_valid = 0;
        r_beat(1, 1);
        calib = 0;
        repeat (3) tick();

        // 2: calib glitch restarts the settle window
        calib = 1;
        repeat (30) tick();
        calib = 0;
        tick();
        calib = 1;
        tick();
        wait_open(n);
        check("t2_resettle_edges", n, SETTLE);

        // 3: read outstanding limit
        for (int i = 0; i < MAXO; i++) ar_send(1'($urandom), $urandom, 8'($urandom));
        check("t3_rd_full", rd_out, 4'd8);
        s_ar_id = 0; s_ar_addr = $urandom; s_ar_len = 8'd1;
        s_ar_size = 3'd5; s_ar_burst = 2'b01; s_ar_valid = 1;
        ar_q.push_back({1'b0, 2'b00, s_ar_addr, 8'd1, 3'd5, 2'b01});
        repeat (4) tick();
        check("t3_ninth_stalls", s_ar_ready, 1'b0);
        r_beat(0, 0);
        check("t3_nonlast_keeps", rd_out, 4'd8);
        r_beat(0, 1);
        check("t3_ready_after_retire", s_ar_ready, 1'b1);
        r_beat(1, 1);
        s_ar_valid = 0;
        check("t3_inc_dec_same_cycle", rd_out, 4'd7);
        for (int i = 0; i < 7; i++) r_beat(1'($urandom), 1);
        check("t3_rd_empty", rd_out, 4'd0);

        // 4: address extension, W held until its AW
        w_present(0);
        w_q.push_back({s_w_data, s_w_strb, 1'b0});
        repeat (3) tick();
        check("t4_w_held", s_w_ready, 1'b0);
        s_aw_id = 1; s_aw_addr = 32'hFFFF_FFC0; s_aw_len = 8'd3;
        s_aw_size = 3'd5; s_aw_burst = 2'b01; s_aw_valid = 1;
        aw_q.push_back({1'b1, 34'h0_FFFF_FFC0, 8'd3, 3'd5, 2'b01});
        #1;
        check("t4_addr_zext", m_aw_addr, 34'h0_FFFF_FFC0);
        check("t4_w_with_aw", s_w_ready, 1'b1);
        tick();
        s_aw_valid = 0;
        s_w_valid = 0;
        w_beat(0);
        w_beat(0);
        w_beat(1);
        check("t4_wr_one", wr_out, 4'd1);
        b_beat(1);
        check("t4_wr_zero", wr_out, 4'd0);

        // 5: flush drains, no new bursts, then re-settles
        for (int i = 0; i < 3; i++) ar_send(1'($urandom), $urandom, 8'd0);
        for (int i = 0; i < 2; i++) begin
            aw_send(1'($urandom), $urandom, 8'd0);
            w_beat(1);
        end
        check("t5_counts", {rd_out, wr_out}, {4'd3, 4'd2});
        flush = 1;
        tick();
        flush = 0;
        s_ar_valid = 1; s_aw_valid = 1;
        repeat (5) tick();
        check("t5_no_new", {s_ar_ready, s_aw_ready, gate_open}, 3'b000);
        s_ar_valid = 0; s_aw_valid = 0;
        for (int i = 0; i < 3; i++) r_beat(1'($urandom), 1);
        b_beat(0);
        b_beat(1);
        // one edge to leave IDLE, then the settle window
        wait_open(n);
        check("t5_reopen_edges", n, SETTLE + 1);

        // 6: async reset in the middle of a write burst
        aw_send(0, $urandom, 8'd7);
        for (int i = 0; i < 3; i++) w_beat(0);
        w_present(0);
        #2;
        rst = 1;
        #1;
        check("t6_async_reset", {gate_open, rd_out, wr_out, s_w_ready, m_w_valid},
              '0);
        repeat (3) tick();
        s_w_valid = 0;
        rst = 0;
        repeat (5) tick();
        check("t6_stays_closed", {gate_open, wr_out}, '0);
        check("queues_drained", ar_q.size() + aw_q.size() + w_q.size() +
              b_q.size() + r_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
